hazard_ctrl_unit: RTL

//  Parametrised pipeline hazard controller for the 5-stage core; supersedes the inline forwarding/stall/Condep logic in decode.

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/hazard_fwd_sel.sv | 51 +++++
 rtl/hazard_ctrl_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: forwarding select
// codes, sequencer state encoding and counter widths.
package hazard_pkg;

  // Operand source selects driven onto the ID-stage forwarding muxes
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_EX  = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  // Sequencer states; 2'b11 is unreachable and recovers to ST_RUN
  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_LDSTALL = 2'b01,
    ST_FLUSH   = 2'b10
  } state_t;

  // Architectural zero register never forwards or scoreboards
  localparam int unsigned REG_ZERO = 0;

  // Sequencer counter covers LOAD_LAT-1 (<=6) and BR_FLUSH-1 (<=2)
  localparam int unsigned CNT_W = 3;
  // Multi-cycle counter covers MD_LAT (<=15)
  localparam int unsigned MD_CNT_W = 4;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one source operand: match each producing stage and
// pick EX > MEM > WB. WB is a candidate only when HAZARD_WB_FWD_EN is defined.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned RA_W = 5
) (
  input  logic [RA_W-1:0] src,
  input  logic            use_src,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_wreg,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_wreg,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_wreg,
  output logic [1:0]      sel
);

  localparam logic [RA_W-1:0] ZERO = RA_W'(REG_ZERO);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = use_src && ex_wreg  && (ex_rd  == src) && (ex_rd  != ZERO);
  assign mem_hit = use_src && mem_wreg && (mem_rd == src) && (mem_rd != ZERO);

`ifdef HAZARD_WB_FWD_EN
  logic wb_hit;
  assign wb_hit = use_src && wb_wreg && (wb_rd == src) && (wb_rd != ZERO);

  // Priority select, youngest producer wins
  always_comb begin
    sel = FWD_REG;
    if (ex_hit)       sel = FWD_EX;
    else if (mem_hit) sel = FWD_MEM;
    else if (wb_hit)  sel = FWD_WB;
  end
`else
  // WB result reaches the regfile in the first half-cycle, so it is ignored
  logic unused_wb;
  assign unused_wb = ^{wb_rd, wb_wreg};

  // Priority select, youngest producer wins
  always_comb begin
    sel = FWD_REG;
    if (ex_hit)       sel = FWD_EX;
    else if (mem_hit) sel = FWD_MEM;
  end
`endif

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller beside the ID stage: operand forwarding selects,
// load-use bubbles, taken-branch flush sequencing and a single-entry
// scoreboard for the multi-cycle (mul/div) unit.
// Optional feature macro: HAZARD_WB_FWD_EN (WB stage as forwarding source).
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned RA_W     = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned BR_FLUSH = 1,
  parameter int unsigned MD_LAT   = 4
) (
  input  logic            Clk,
  input  logic            Clrn,
  input  logic [RA_W-1:0] Rs,
  input  logic [RA_W-1:0] Rt,
  input  logic            UseRs,
  input  logic            UseRt,
  input  logic            MdIssue,
  input  logic [RA_W-1:0] MdRd,
  input  logic [RA_W-1:0] eRd,
  input  logic            eWreg,
  input  logic            eLoad,
  input  logic [RA_W-1:0] mRd,
  input  logic            mWreg,
  input  logic [RA_W-1:0] wRd,
  input  logic            wWreg,
  input  logic            eTaken,
  output logic [1:0]      FwdA,
  output logic [1:0]      FwdB,
  output logic            Wpcir,
  output logic            Bubble,
  output logic            Flush,
  output logic            MdBusy,
  output logic            MdDone
);

  localparam logic [RA_W-1:0]     ZERO    = RA_W'(REG_ZERO);
  localparam logic [CNT_W-1:0]    LD_INIT = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0]    BR_INIT = CNT_W'(BR_FLUSH - 1);
  localparam logic [MD_CNT_W-1:0] MD_INIT = MD_CNT_W'(MD_LAT);

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [MD_CNT_W-1:0]  md_cnt;
  logic [RA_W-1:0]      md_rd;

  logic load_use;
  logic ld_stall;
  logic md_dep;
  logic md_stall;
  logic md_issue;

  hazard_fwd_sel #(.RA_W(RA_W)) u_fwd_a (
    .src      (Rs),
    .use_src  (UseRs),
    .ex_rd    (eRd),
    .ex_wreg  (eWreg),
    .mem_rd   (mRd),
    .mem_wreg (mWreg),
    .wb_rd    (wRd),
    .wb_wreg  (wWreg),
    .sel      (FwdA)
  );

  hazard_fwd_sel #(.RA_W(RA_W)) u_fwd_b (
    .src      (Rt),
    .use_src  (UseRt),
    .ex_rd    (eRd),
    .ex_wreg  (eWreg),
    .mem_rd   (mRd),
    .mem_wreg (mWreg),
    .wb_rd    (wRd),
    .wb_wreg  (wWreg),
    .sel      (FwdB)
  );

  assign load_use = eLoad && eWreg && (eRd != ZERO) &&
                    ((UseRs && (Rs == eRd)) || (UseRt && (Rt == eRd)));

  // Sequencer next state: the detect cycle stalls or flushes combinationally,
  // so the held state only covers the remaining LOAD_LAT-1 / BR_FLUSH-1 cycles
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ld_stall  = 1'b0;
    Flush     = 1'b0;
    case (state)
      ST_RUN: begin
        if (eTaken) begin
          Flush = 1'b1;
          if (BR_INIT != '0) begin
            state_nxt = ST_FLUSH;
            cnt_nxt   = BR_INIT;
          end
        end else if (load_use) begin
          ld_stall = 1'b1;
          if (LD_INIT != '0) begin
            state_nxt = ST_LDSTALL;
            cnt_nxt   = LD_INIT;
          end
        end
      end
      ST_LDSTALL: begin
        if (eTaken) begin
          Flush = 1'b1;
          if (BR_INIT != '0) begin
            state_nxt = ST_FLUSH;
            cnt_nxt   = BR_INIT;
          end else begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
          end
        end else begin
          ld_stall = 1'b1;
          cnt_nxt  = cnt - 1'b1;
          if (cnt == CNT_W'(1)) state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        Flush = 1'b1;
        if (eTaken) begin
          cnt_nxt = BR_INIT;
        end else begin
          cnt_nxt = cnt - 1'b1;
          if (cnt == CNT_W'(1)) state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign MdBusy = (md_cnt != '0);
  assign MdDone = (md_cnt == MD_CNT_W'(1));
  assign md_dep = (md_rd != ZERO) &&
                  ((UseRs && (Rs == md_rd)) || (UseRt && (Rt == md_rd)));

  // Dependent reads release on the MdDone cycle (result arrives via WB path);
  // a second issue waits for the whole busy window
  assign md_stall = MdBusy && !Flush && ((md_dep && !MdDone) || MdIssue);

  assign Bubble   = ld_stall || md_stall;
  assign Wpcir    = !Bubble;
  assign md_issue = MdIssue && Wpcir && !Flush;

  // Sequencer state register
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Multi-cycle scoreboard: load on issue, count down, clear after MdDone
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      md_cnt <= '0;
      md_rd  <= '0;
    end else if (md_issue) begin
      md_cnt <= MD_INIT;
      md_rd  <= MdRd;
    end else if (MdBusy) begin
      md_cnt <= md_cnt - 1'b1;
      if (MdDone) md_rd <= '0;
    end
  end

endmodule
